// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner: debounce FSM states,
// per-frame classification and the key-code width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_class_t;

  function automatic int key_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column ring with per-column dwell counter; accumulates row hits over one
// full scan frame and classifies the frame at its last sample.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int KEY_W    = key_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_COLS-1:0] cols,
  input  logic [NUM_ROWS-1:0] rows,
  output logic                frame_done,
  output frame_class_t        frame_class,
  output logic [KEY_W-1:0]    frame_code
);

  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] dwell;
  logic [COL_W-1:0] col_idx;
  logic [1:0]       acc_cnt;
  logic [KEY_W-1:0] acc_code;
  logic             sample;
  logic             last_col;
  logic [1:0]       row_cnt;
  logic [KEY_W-1:0] row_code;
  logic [2:0]       sum;
  logic [1:0]       total_cnt;

  assign sample     = (dwell == DIV_W'(SCAN_DIV - 1));
  assign last_col   = (col_idx == COL_W'(NUM_COLS - 1));
  assign frame_done = sample && last_col;
  assign cols       = NUM_COLS'(1) << col_idx;

  // Hit counts saturate at 2: anything beyond one key is simply MULTI.
  always_comb begin
    row_cnt  = 2'd0;
    row_code = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (rows[r]) begin
        row_code = KEY_W'(int'(col_idx) * NUM_ROWS + r);
        if (row_cnt != 2'd2) row_cnt = row_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    sum        = {1'b0, acc_cnt} + {1'b0, row_cnt};
    total_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    frame_code = (acc_cnt == 2'd1) ? acc_code : row_code;
    case (total_cnt)
      2'd0:    frame_class = NONE;
      2'd1:    frame_class = SINGLE;
      default: frame_class = MULTI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell    <= '0;
      col_idx  <= '0;
      acc_cnt  <= 2'd0;
      acc_code <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= last_col ? '0 : col_idx + 1'b1;
      if (last_col) begin
        acc_cnt  <= 2'd0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= total_cnt;
        acc_code <= frame_code;
      end
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad front end: frame-level press/release debounce, multi-key rejection
// and a one-entry valid/ready event register. KEYPAD_REPEAT_EN adds auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int KEY_W        = key_width(NUM_ROWS, NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_COLS-1:0] cols,
  input  logic [NUM_ROWS-1:0] rows,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  input  logic                key_ready,
  output logic                key_held,
  output logic                overrun
);

  if (NUM_ROWS < 2 || NUM_ROWS > 8 || NUM_COLS < 2 || NUM_COLS > 8 || SCAN_DIV < 2 ||
      DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      KEY_W != key_width(NUM_ROWS, NUM_COLS)) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

  logic             frame_done;
  frame_class_t     frame_class;
  logic [KEY_W-1:0] frame_code;

  state_t           state, state_n;
  logic [KEY_W-1:0] cand, cand_n;
  logic [3:0]       cnt, cnt_n;
  logic             press_emit;
  logic             repeat_emit;
  logic             emit;

  keypad_col_scan #(
    .NUM_ROWS(NUM_ROWS),
    .NUM_COLS(NUM_COLS),
    .SCAN_DIV(SCAN_DIV),
    .KEY_W   (KEY_W)
  ) u_col_scan (
    .clk        (clk),
    .rst        (rst),
    .cols       (cols),
    .rows       (rows),
    .frame_done (frame_done),
    .frame_class(frame_class),
    .frame_code (frame_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cand_n     = cand;
    cnt_n      = cnt;
    press_emit = 1'b0;
    if (frame_done) begin
      unique case (state)
        IDLE: begin
          if (frame_class == SINGLE) begin
            cand_n = frame_code;
            cnt_n  = 4'd1;
            if (cnt_n == DB_LAST) begin
              state_n    = PRESSED;
              press_emit = 1'b1;
            end else begin
              state_n = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (frame_class == SINGLE && frame_code == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == DB_LAST) begin
              state_n    = PRESSED;
              press_emit = 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        end
        PRESSED: begin
          if (frame_class == NONE) begin
            cnt_n   = 4'd1;
            state_n = (cnt_n == DB_LAST) ? IDLE : RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (frame_class == NONE) begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == DB_LAST) state_n = IDLE;
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Counts held frames in PRESSED only; phase 0 waits REPEAT_DELAY, phase 1 REPEAT_RATE.
  logic [15:0] rpt_cnt;
  logic [15:0] rpt_next;
  logic        rpt_phase;
  logic        rpt_tick;
  logic        rpt_hit;

  assign rpt_tick    = frame_done && (state == PRESSED) && (frame_class != NONE);
  assign rpt_next    = rpt_cnt + 16'd1;
  assign rpt_hit     = (rpt_next == (rpt_phase ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY)));
  assign repeat_emit = rpt_tick && rpt_hit;

  always_ff @(posedge clk) begin
    if (rst || press_emit || state == IDLE) begin
      rpt_cnt   <= 16'd0;
      rpt_phase <= 1'b0;
    end else if (rpt_tick) begin
      if (rpt_hit) begin
        rpt_cnt   <= 16'd0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt <= rpt_next;
      end
    end
  end
`else
  assign repeat_emit = 1'b0;
`endif

  assign emit     = press_emit || repeat_emit;
  assign key_held = (state == PRESSED) || (state == RELEASE_DB);

  // A pending, unaccepted event wins: a newer one is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= cand_n;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix emulation, frame-level reference
// model compared every cycle, plus directed scenarios with literal checks.
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int SD = 2;
  localparam int DB = 3;
  localparam int RD = 2;
  localparam int RR = 1;
  localparam int F  = NC * SD;
  localparam int KW = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NC-1:0] cols;
  logic [NR-1:0] rows;
  logic          key_valid;
  logic [KW-1:0] key_code;
  logic          key_ready;
  logic          key_held;
  logic          overrun;
  logic [NR*NC-1:0] keys;

  int tests = 0;
  int fails = 0;
  int xfer_q[$];
  int ovr_seen = 0;

  bit m_known = 1'b0;
  int m_cyc, m_seen, m_seen_code, m_down, m_cand, m_agree, m_rep;
  int e_valid, e_code, e_held, e_ovr;

  keypad_scanner #(
    .NUM_ROWS    (NR),
    .NUM_COLS    (NC),
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cols     (cols),
    .rows     (rows),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical matrix: a pressed key connects its column to its row.
  always_comb begin
    rows = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (cols[c] && keys[c*NR + r]) rows[r] = 1'b1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NR*NC-1:0] k, input logic rdy, input int cycles);
    keys      = k;
    key_ready = rdy;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    int  col;
    bit  emit;
    if (m_known) begin
      checkOutput("cols", int'(cols), 1 << ((m_cyc / SD) % NC));
      checkOutput("key_valid", int'(key_valid), e_valid);
      checkOutput("key_code", int'(key_code), e_code);
      checkOutput("key_held", int'(key_held), e_held);
      checkOutput("overrun", int'(overrun), e_ovr);
    end
    if (!rst && key_valid && key_ready) xfer_q.push_back(int'(key_code));
    if (overrun) ovr_seen++;

    if (rst) begin
      m_known = 1'b1;
      m_cyc = 0; m_seen = 0; m_seen_code = 0;
      m_down = 0; m_cand = 0; m_agree = 0; m_rep = 0;
      e_valid = 0; e_code = 0; e_held = 0; e_ovr = 0;
    end else if (m_known) begin
      emit = 1'b0;
      if (m_cyc % SD == SD - 1) begin
        col = (m_cyc / SD) % NC;
        for (int r = 0; r < NR; r++)
          if (keys[col*NR + r]) begin
            m_seen++;
            m_seen_code = col * NR + r;
          end
        if (col == NC - 1) begin
          if (m_down == 0) begin
            if (m_seen == 1 && (m_agree == 0 || m_seen_code == m_cand)) begin
              m_cand = m_seen_code;
              m_agree++;
              if (m_agree == DB) begin
                m_down = 1; m_agree = 0; m_rep = 0; emit = 1'b1;
              end
            end else begin
              m_agree = 0;
            end
          end else if (m_seen == 0) begin
            m_agree++;
            if (m_agree == DB) begin
              m_down = 0; m_agree = 0;
            end
          end else begin
            if (REPEAT_ON && m_agree == 0) begin
              m_rep++;
              if (m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0)) emit = 1'b1;
            end
            m_agree = 0;
          end
          m_seen = 0;
        end
      end
      e_ovr = 0;
      if (emit) begin
        if (e_valid == 0 || key_ready) begin
          e_valid = 1;
          e_code  = m_cand;
        end else begin
          e_ovr = 1;
        end
      end else if (e_valid == 1 && key_ready) begin
        e_valid = 0;
      end
      e_held = m_down;
      m_cyc++;
    end
  end

  initial begin
    int ov0;
    rst       = 1'b1;
    keys      = '0;
    key_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_cols", int'(cols), 1);
    checkOutput("reset_valid", int'(key_valid), 0);
    checkOutput("reset_code", int'(key_code), 0);
    checkOutput("reset_held", int'(key_held), 0);
    checkOutput("reset_overrun", int'(overrun), 0);

    // Key 6 (col 1, row 2): accepted at the third frame end.
    applyStimulus(16'h0040, 1'b1, 24);
    checkOutput("t1_valid_rise", int'(key_valid), 1);
    checkOutput("t1_code", int'(key_code), 6);
    checkOutput("t1_held_rise", int'(key_held), 1);
    applyStimulus(16'h0040, 1'b1, 1);
    checkOutput("t1_valid_taken", int'(key_valid), 0);
    applyStimulus(16'h0040, 1'b1, 15);
    applyStimulus(16'h0000, 1'b1, 2 * F);
    checkOutput("t1_held_2none", int'(key_held), 1);
    applyStimulus(16'h0000, 1'b1, F);
    checkOutput("t1_released", int'(key_held), 0);
    checkOutput("t1_events", xfer_q.size(), REPEAT_ON ? 2 : 1);
    checkOutput("t1_first_code", (xfer_q.size() > 0) ? xfer_q[0] : -1, 6);

    // Bounce: alternate pressed/released frames never completes debounce.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h0040, 1'b1, F);
      applyStimulus(16'h0000, 1'b1, F);
    end
    checkOutput("t2_bounce_events", xfer_q.size(), REPEAT_ON ? 2 : 1);
    checkOutput("t2_bounce_held", int'(key_held), 0);

    // Two keys together are rejected; adding a key while held is ignored.
    applyStimulus(16'h0240, 1'b1, 4 * F);
    checkOutput("t3_multi_events", xfer_q.size(), REPEAT_ON ? 2 : 1);
    checkOutput("t3_multi_held", int'(key_held), 0);
    applyStimulus(16'h0000, 1'b1, F);
    applyStimulus(16'h0040, 1'b1, 4 * F);
    checkOutput("t3_single_held", int'(key_held), 1);
    applyStimulus(16'h0240, 1'b1, 3 * F);
    checkOutput("t3_add_held", int'(key_held), 1);
    applyStimulus(16'h0000, 1'b1, 4 * F);
    checkOutput("t3_add_events", xfer_q.size(), REPEAT_ON ? 6 : 2);
    checkOutput("t3_released", int'(key_held), 0);

    // Consumer stalled: key 3 waits, key 5 is dropped with one overrun pulse.
    ov0 = ovr_seen;
    applyStimulus(16'h0008, 1'b0, 4 * F);
    checkOutput("t4_pending_valid", int'(key_valid), 1);
    checkOutput("t4_pending_code", int'(key_code), 3);
    applyStimulus(16'h0000, 1'b0, 4 * F);
    applyStimulus(16'h0020, 1'b0, 4 * F);
    checkOutput("t4_kept_code", int'(key_code), 3);
    checkOutput("t4_kept_valid", int'(key_valid), 1);
    checkOutput("t4_overruns", ovr_seen - ov0, 1);
    applyStimulus(16'h0020, 1'b1, 1);
    checkOutput("t4_drained_valid", int'(key_valid), 0);
    checkOutput("t4_drained_code", (xfer_q.size() > 0) ? xfer_q[xfer_q.size()-1] : -1, 3);
    applyStimulus(16'h0000, 1'b1, 4 * F - 1);
    checkOutput("t4_events", xfer_q.size(), REPEAT_ON ? 7 : 3);

    // Reset in the middle of press debounce discards the partial count.
    applyStimulus(16'h0040, 1'b1, 2 * F);
    rst = 1'b1;
    applyStimulus(16'h0040, 1'b1, 1);
    checkOutput("t5_rst_cols", int'(cols), 1);
    checkOutput("t5_rst_valid", int'(key_valid), 0);
    checkOutput("t5_rst_code", int'(key_code), 0);
    checkOutput("t5_rst_held", int'(key_held), 0);
    rst = 1'b0;
    applyStimulus(16'h0040, 1'b1, 2 * F);
    checkOutput("t5_no_event_held", int'(key_held), 0);
    applyStimulus(16'h0000, 1'b1, 2 * F);
    checkOutput("t5_events", xfer_q.size(), REPEAT_ON ? 7 : 3);

`ifdef KEYPAD_REPEAT_EN
    // Key 0 held: acceptance plus repeats at +2, +3, +4, +5 frames.
    applyStimulus(16'h0001, 1'b1, 8 * F);
    applyStimulus(16'h0000, 1'b1, 4 * F);
    checkOutput("t6_repeat_events", xfer_q.size(), 12);
    checkOutput("t6_repeat_code", (xfer_q.size() > 0) ? xfer_q[xfer_q.size()-1] : -1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
